// File: rtl/app_readout_pkg.sv
// rtl/app_readout_pkg.sv - shared state type and frame constants for the timestamp serial readout
package app_readout_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam logic START_BIT     = 1'b0;
    localparam logic STOP_BIT      = 1'b1;
    localparam int   DEF_WORDWIDTH = 16;
    localparam int   FRAME_BITS    = DEF_WORDWIDTH + 3;

    // Start, data, parity and stop bits for an arbitrary word width.
    function automatic int frame_len(input int wordwidth);
        return wordwidth + 3;
    endfunction

endpackage

// File: rtl/tstamp_ser_tx_if.sv
// rtl/tstamp_ser_tx_if.sv - FIFO read-port bundle between the timestamp FIFO and the serialiser
interface tstamp_ser_tx_if #(
    parameter int WORDWIDTH = 16
);
    logic [WORDWIDTH-1:0] fifo_data_i;
    logic                 fifo_empty_i;
    logic                 fifo_re_o;

    // master is the reader (serialiser), slave is the FIFO.
    modport master (input fifo_data_i, input fifo_empty_i, output fifo_re_o);
    modport slave  (output fifo_data_i, output fifo_empty_i, input fifo_re_o);
endinterface

// File: rtl/bit_tick_div.sv
// rtl/bit_tick_div.sv - CLKDIV prescaler emitting a one-cycle tick at terminal count
module bit_tick_div #(
    parameter int CLKDIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic clr_i,
    output logic tick_o
);
    localparam logic [7:0] TERM = 8'(CLKDIV - 1);

    logic [7:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!rstb || clr_i || tick_o) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign tick_o = (div_cnt == TERM);

endmodule

// File: rtl/tstamp_ser_tx.sv
// rtl/tstamp_ser_tx.sv - drains the timestamp FIFO into a framed, even-parity serial stream
module tstamp_ser_tx
    import app_readout_pkg::*;
#(
    parameter int WORDWIDTH = 16,
    parameter int CLKDIV    = 4,
    parameter int CNTWIDTH  = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                en_i,
    tstamp_ser_tx_if.master     fifo,
    output logic                ser_o,
    output logic                frame_o,
    output logic                busy_o,
    output logic [CNTWIDTH-1:0] sent_cnt_o
);
    localparam int              FLEN     = frame_len(WORDWIDTH);
    localparam int              IDXW     = $clog2(FLEN);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FLEN - 1);

    ser_state_t      state, state_nxt;
    logic [FLEN-1:0] shreg;
    logic [IDXW-1:0] bit_idx;
    logic            tick;
    logic            pop;
    logic            frame_done;

    bit_tick_div #(.CLKDIV(CLKDIV)) u_div (
        .clk    (clk),
        .rstb   (rstb),
        .clr_i  (pop),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pop is gated by rstb so no read strobe escapes while reset is held.
    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        frame_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (rstb && en_i && !fifo.fifo_empty_i) begin
                    pop       = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick && bit_idx == LAST_IDX) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        fifo.fifo_re_o = pop;
        frame_o        = (state == SHIFT);
        busy_o         = pop || (state == SHIFT);
        ser_o          = (state == SHIFT) ? shreg[FLEN-1] : 1'b1;
    end

    // The whole frame is preloaded so shifting out MSB first emits start, data, parity, stop.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            shreg      <= '1;
            bit_idx    <= '0;
            sent_cnt_o <= '0;
        end else begin
            if (pop) begin
                shreg   <= {START_BIT, fifo.fifo_data_i, ^fifo.fifo_data_i, STOP_BIT};
                bit_idx <= '0;
            end else if (state == SHIFT && tick) begin
                shreg   <= {shreg[FLEN-2:0], 1'b1};
                bit_idx <= bit_idx + IDXW'(1);
            end
            if (frame_done) begin
                sent_cnt_o <= sent_cnt_o + CNTWIDTH'(1);
            end
        end
    end

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rstb)
        !(fifo.fifo_re_o && fifo.fifo_empty_i));

endmodule

// File: tb/tb_tstamp_ser_tx.sv
// tb/tb_tstamp_ser_tx.sv - self-checking bench for tstamp_ser_tx at CLKDIV=4 and CLKDIV=1
module tb_tstamp_ser_tx;
    import app_readout_pkg::*;

    localparam int WW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstb [2];
    logic          en   [2];
    logic          act_re [2], act_ser [2], act_frame [2], act_busy [2];
    logic [CW-1:0] act_cnt [2];
    logic          ser_a, frame_a, busy_a, ser_b, frame_b, busy_b;
    logic [CW-1:0] cnt_a, cnt_b;

    tstamp_ser_tx_if #(.WORDWIDTH(WW)) ifa ();
    tstamp_ser_tx_if #(.WORDWIDTH(WW)) ifb ();

    tstamp_ser_tx #(.WORDWIDTH(WW), .CLKDIV(4), .CNTWIDTH(CW)) u_dut_a (
        .clk(clk), .rstb(rstb[0]), .en_i(en[0]), .fifo(ifa),
        .ser_o(ser_a), .frame_o(frame_a), .busy_o(busy_a), .sent_cnt_o(cnt_a)
    );
    tstamp_ser_tx #(.WORDWIDTH(WW), .CLKDIV(1), .CNTWIDTH(CW)) u_dut_b (
        .clk(clk), .rstb(rstb[1]), .en_i(en[1]), .fifo(ifb),
        .ser_o(ser_b), .frame_o(frame_b), .busy_o(busy_b), .sent_cnt_o(cnt_b)
    );

    assign act_re[0] = ifa.fifo_re_o;  assign act_re[1] = ifb.fifo_re_o;
    assign act_ser[0] = ser_a;         assign act_ser[1] = ser_b;
    assign act_frame[0] = frame_a;     assign act_frame[1] = frame_b;
    assign act_busy[0] = busy_a;       assign act_busy[1] = busy_b;
    assign act_cnt[0] = cnt_a;         assign act_cnt[1] = cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int clkdiv [2] = '{4, 1};

    task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, a, e);
        end
    endtask

    // Bench-side FIFO: head word shown while non-empty, popped after a cycle with fifo_re_o.
    logic [WW-1:0] fmem [2][0:1023];
    int            fhead [2] = '{0, 0};
    int            ftail [2] = '{0, 0};
    logic          f_empty [2];
    logic [WW-1:0] f_data [2];
    logic          pend [2] = '{1'b0, 1'b0};

    task automatic push(input int d, input logic [WW-1:0] w);
        fmem[d][ftail[d] % 1024] = w;
        ftail[d]++;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            f_empty[d] = 1'b1;
            f_data[d]  = '0;
        end
        forever begin
            ifa.fifo_data_i = f_data[0];  ifa.fifo_empty_i = f_empty[0];
            ifb.fifo_data_i = f_data[1];  ifb.fifo_empty_i = f_empty[1];
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (pend[d] && fhead[d] != ftail[d]) fhead[d]++;
                f_empty[d] = (fhead[d] == ftail[d]);
                f_data[d]  = fmem[d][fhead[d] % 1024];
            end
        end
    end

    // Model: a popped word becomes a 19-bit frame played out for 19*CLKDIV cycles.
    logic                  p_rstb [2] = '{1'b0, 1'b0};
    logic                  p_re   [2] = '{1'b0, 1'b0};
    logic [WW-1:0]         p_data [2];
    logic                  m_act  [2] = '{1'b0, 1'b0};
    int                    m_k    [2] = '{0, 0};
    int                    m_cnt  [2] = '{0, 0};
    logic [FRAME_BITS-1:0] m_fr   [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic e_re, e_ser;
            if (!p_rstb[d]) begin
                m_act[d] = 1'b0;
                m_cnt[d] = 0;
            end else if (p_re[d]) begin
                m_act[d] = 1'b1;
                m_k[d]   = 0;
                m_fr[d]  = {START_BIT, p_data[d], ^p_data[d], STOP_BIT};
            end else if (m_act[d]) begin
                m_k[d]++;
                if (m_k[d] == FRAME_BITS * clkdiv[d]) begin
                    m_act[d] = 1'b0;
                    m_cnt[d] = (m_cnt[d] + 1) % 256;
                end
            end
            e_re  = rstb[d] && !m_act[d] && en[d] && !f_empty[d];
            e_ser = m_act[d] ? m_fr[d][FRAME_BITS - 1 - m_k[d] / clkdiv[d]] : 1'b1;
            chk("fifo_re_o", d, act_re[d], e_re);
            chk("ser_o", d, act_ser[d], e_ser);
            chk("frame_o", d, act_frame[d], m_act[d]);
            chk("busy_o", d, act_busy[d], m_act[d] || e_re);
            chk("sent_cnt_o", d, act_cnt[d], m_cnt[d]);
            p_rstb[d] = rstb[d];
            p_re[d]   = e_re;
            p_data[d] = f_data[d];
            pend[d]   = act_re[d];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(input int d);
        int c = 0;
        while (!act_frame[d] && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_frame", d, act_frame[d], 1);
    endtask

    task automatic observe(input int d, input int ncyc, output int n_re, output int n_fr,
                           output int n_st, output int span, output logic [FRAME_BITS-1:0] bits);
        int j = 0, first = -1, last = -1;
        logic prev_f = 1'b0;
        n_re = 0; n_fr = 0; n_st = 0; bits = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (act_re[d]) n_re++;
            if (act_frame[d]) begin
                if (!prev_f) begin n_st++; j = 0; end
                if (j % clkdiv[d] == clkdiv[d] / 2) bits = {bits[FRAME_BITS-2:0], act_ser[d]};
                j++;
                n_fr++;
                if (first < 0) first = c;
                last = c;
            end
            prev_f = act_frame[d];
        end
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    int n_re, n_fr, n_st, span;
    logic [FRAME_BITS-1:0] bits;

    initial begin
        rstb[0] = 1'b0; rstb[1] = 1'b0;
        en[0] = 1'b1;   en[1] = 1'b1;
        push(0, 16'h5555);
        push(1, 16'hA5A5); push(1, 16'hFFFF); push(1, 16'h0000);

        // Reset held with a non-empty FIFO and enable high.
        repeat (5) begin
            @(negedge clk);
            chk("rst_re_a", 0, act_re[0], 0);
            chk("rst_re_b", 1, act_re[1], 0);
            chk("rst_ser", 0, act_ser[0], 1);
            chk("rst_cnt", 0, act_cnt[0], 0);
        end

        step(); rstb[0] = 1'b1;
        observe(0, 90, n_re, n_fr, n_st, span, bits);
        chk("w5555_pops", 0, n_re, 1);
        chk("w5555_frame_cycles", 0, n_fr, 76);
        chk("w5555_bits", 0, bits, 19'b0_0101010101010101_0_1);
        chk("w5555_cnt", 0, act_cnt[0], 1);

        step(); rstb[1] = 1'b1;
        observe(1, 70, n_re, n_fr, n_st, span, bits);
        chk("b2b_pops", 1, n_re, 3);
        chk("b2b_frames", 1, n_st, 3);
        chk("b2b_frame_cycles", 1, n_fr, 57);
        chk("b2b_span", 1, span, 59);
        chk("b2b_last_bits", 1, bits, 19'b0_0000000000000000_0_1);
        chk("b2b_cnt", 1, act_cnt[1], 3);

        step(); push(0, 16'h0001);
        observe(0, 90, n_re, n_fr, n_st, span, bits);
        chk("w0001_frame_cycles", 0, n_fr, 76);
        chk("w0001_bits", 0, bits, 19'b0_0000000000000001_1_1);
        chk("w0001_cnt", 0, act_cnt[0], 2);

        // Enable dropped at bit 5: frame completes, queued word stays.
        step(); push(0, 16'h1234); push(0, 16'h4321);
        wait_frame(0);
        repeat (20) step();
        en[0] = 1'b0;
        observe(0, 100, n_re, n_fr, n_st, span, bits);
        chk("endrop_pops", 0, n_re, 0);
        chk("endrop_cnt", 0, act_cnt[0], 3);
        chk("endrop_fifo_left", 0, f_empty[0], 0);

        // Reset at bit 10 of the next frame.
        step(); en[0] = 1'b1;
        wait_frame(0);
        repeat (40) step();
        rstb[0] = 1'b0;
        @(negedge clk);
        chk("midrst_before_edge", 0, act_frame[0], 1);
        @(negedge clk);
        chk("midrst_ser", 0, act_ser[0], 1);
        chk("midrst_frame", 0, act_frame[0], 0);
        chk("midrst_busy", 0, act_busy[0], 0);
        chk("midrst_cnt", 0, act_cnt[0], 0);
        step(); rstb[0] = 1'b1;

        // 253 more frames on the CLKDIV=1 instance bring the 8-bit count through 256.
        step();
        for (int i = 0; i < 253; i++) push(1, WW'(i * 16'h0301 + 16'h0F0F));
        observe(1, 253 * 20 + 20, n_re, n_fr, n_st, span, bits);
        chk("wrap_frames", 1, n_st, 253);
        chk("wrap_cnt", 1, act_cnt[1], 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
